matrix_sequencer: RTL and testbench

- Upstream feeder and result collector for inner_product; owns the C = A x B loop.
- Accepts two flattened NxN single-precision matrices and walks the result indices (r,c) in row-major order.
- For each index, presents row r of A and column c of B to one inner_product instance, captures the returned word into C[r][c], then returns the full C matrix on a stb/ack handshake.

---
 rtl/matrix_pkg.sv | 16 +
 rtl/matrix_index_counter.sv | 46 ++++
 rtl/matrix_sequencer.sv | 136 +++++++++++++
 tb/tb_matrix_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix sequencer: word width, FSM encoding and
// the flattened-matrix element offset.
package matrix_pkg;
  localparam int WORD_W = 32;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_STORE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  // Bit offset of element [r][c] in a flattened NxN matrix.
  function automatic int idx(input int r, input int c, input int n);
    return WORD_W * (r * n + c);
  endfunction
endpackage

// File: rtl/matrix_index_counter.sv
// Row-major (r,c) walker over an NxN grid; exposes the following index so the
// next operands can be loaded on the same edge the counter advances.
module matrix_index_counter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          adv_i,
  output logic [IW-1:0] r_o,
  output logic [IW-1:0] c_o,
  output logic [IW-1:0] r_nx_o,
  output logic [IW-1:0] c_nx_o,
  output logic          last_o
);
  localparam logic [IW-1:0] MAX = IW'(N - 1);

  logic [IW-1:0] r_q, c_q;

  assign r_o    = r_q;
  assign c_o    = c_q;
  assign last_o = (r_q == MAX) && (c_q == MAX);

  always_comb begin
    r_nx_o = r_q;
    c_nx_o = c_q + IW'(1);
    if (c_q == MAX) begin
      c_nx_o = '0;
      r_nx_o = r_q + IW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q <= '0;
      c_q <= '0;
    end else if (clr_i) begin
      r_q <= '0;
      c_q <= '0;
    end else if (adv_i) begin
      r_q <= r_nx_o;
      c_q <= c_nx_o;
    end
  end
endmodule

// File: rtl/matrix_sequencer.sv
// C = A x B loop: feeds row r of A and column c of B to one inner_product,
// collects each returned word into C[r][c], then offers C on a stb/ack.
module matrix_sequencer
  import matrix_pkg::*;
#(
  parameter int number_of_elements = 4
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic [WORD_W*number_of_elements*number_of_elements-1:0] matrix_a,
  input  logic [WORD_W*number_of_elements*number_of_elements-1:0] matrix_b,
  input  logic                                                matrix_a_stb,
  input  logic                                                matrix_b_stb,
  output logic                                                matrix_a_ack,
  output logic                                                matrix_b_ack,
  output logic [WORD_W*number_of_elements*number_of_elements-1:0] result,
  output logic                                                result_stb,
  input  logic                                                result_ack,
  output logic [WORD_W*number_of_elements-1:0]                row,
  output logic [WORD_W*number_of_elements-1:0]                column,
  output logic                                                row_o_stb,
  output logic                                                column_o_stb,
  input  logic                                                row_i_ack,
  input  logic                                                column_i_ack,
  input  logic [WORD_W-1:0]                                   ip_out,
  input  logic                                                ip_out_stb,
  output logic                                                ip_out_ack
);
  localparam int N  = number_of_elements;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int EW = (N * N > 1) ? $clog2(N * N) : 1;

  typedef logic [N*N-1:0][WORD_W-1:0] mat_t;
  typedef logic [N-1:0][WORD_W-1:0]   vec_t;

  function automatic vec_t get_row(input mat_t m, input logic [IW-1:0] r);
    vec_t v;
    for (int k = 0; k < N; k++) v[k] = m[EW'(int'(r) * N + k)];
    return v;
  endfunction

  function automatic vec_t get_col(input mat_t m, input logic [IW-1:0] c);
    vec_t v;
    for (int k = 0; k < N; k++) v[k] = m[EW'(k * N + int'(c))];
    return v;
  endfunction

  logic [2:0]    state_q, state_d;
  logic          stb_prev_q, ack_q, stb_q, ipack_q, rstb_q;
  mat_t          a_q, b_q, c_q, a_in, b_in;
  vec_t          row_q, col_q;
  logic [IW-1:0] r, c, r_nx, c_nx;
  logic          last, load, accept, capture, store, next_elem, finish;

  assign a_in = matrix_a;
  assign b_in = matrix_b;

  matrix_index_counter #(.N(N), .IW(IW)) u_idx (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (load),
    .adv_i  (store),
    .r_o    (r),
    .c_o    (c),
    .r_nx_o (r_nx),
    .c_nx_o (c_nx),
    .last_o (last)
  );

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    accept  = 1'b0;
    capture = 1'b0;
    finish  = 1'b0;
    case (state_q)
      S_IDLE:  if (matrix_a_stb && matrix_b_stb) begin load = 1'b1; state_d = S_ISSUE; end
      S_ISSUE: if (row_i_ack && column_i_ack) begin accept = 1'b1; state_d = S_WAIT; end
      // Only a fresh rising edge counts; a result left high from before is stale.
      S_WAIT:  if (ip_out_stb && !stb_prev_q) begin capture = 1'b1; state_d = S_STORE; end
      S_STORE: state_d = last ? S_DONE : S_ISSUE;
      S_DONE:  if (result_ack) begin finish = 1'b1; state_d = S_IDLE; end
      default: state_d = S_IDLE;
    endcase
  end

  assign store     = (state_q == S_STORE);
  assign next_elem = store && !last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      stb_prev_q <= 1'b0;
      ack_q      <= 1'b0;
      stb_q      <= 1'b0;
      ipack_q    <= 1'b0;
      rstb_q     <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= '0;
      row_q      <= '0;
      col_q      <= '0;
    end else begin
      state_q    <= state_d;
      stb_prev_q <= ip_out_stb;
      ack_q      <= load;
      // Operands are loaded only on entry to ISSUE so they stay put while stb is up.
      if (load) begin
        a_q   <= a_in;
        b_q   <= b_in;
        row_q <= get_row(a_in, '0);
        col_q <= get_col(b_in, '0);
      end else if (next_elem) begin
        row_q <= get_row(a_q, r_nx);
        col_q <= get_col(b_q, c_nx);
      end
      if (load || next_elem) stb_q <= 1'b1;
      else if (accept)       stb_q <= 1'b0;
      if (load || next_elem) ipack_q <= 1'b1;
      else if (capture)      ipack_q <= 1'b0;
      if (capture) c_q[EW'(int'(r) * N + int'(c))] <= ip_out;
      if (store && last) rstb_q <= 1'b1;
      else if (finish)   rstb_q <= 1'b0;
    end
  end

  assign matrix_a_ack = ack_q;
  assign matrix_b_ack = ack_q;
  assign row          = row_q;
  assign column       = col_q;
  assign row_o_stb    = stb_q;
  assign column_o_stb = stb_q;
  assign ip_out_ack   = ipack_q;
  assign result       = c_q;
  assign result_stb   = rstb_q;
endmodule

// File: tb/tb_matrix_sequencer.sv
// Bench for matrix_sequencer: behavioural inner_product model plus a result
// scoreboard fed from a reference C = f(A rows, B columns).
module tb_matrix_sequencer;
  import matrix_pkg::*;

  localparam int N  = 4;
  localparam int MW = WORD_W * N * N;
  localparam int VW = WORD_W * N;
  typedef logic [31:0] vec_t [N];

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [MW-1:0] matrix_a = '0, matrix_b = '0, result;
  logic          matrix_a_stb = 1'b0, matrix_b_stb = 1'b0, matrix_a_ack, matrix_b_ack;
  logic          result_stb, result_ack = 1'b0;
  logic [VW-1:0] row, column;
  logic          row_o_stb, column_o_stb, ip_out_ack;
  logic          row_i_ack = 1'b0, column_i_ack = 1'b0, ip_out_stb = 1'b0;
  logic [31:0]   ip_out = '0;

  matrix_sequencer #(.number_of_elements(N)) dut (
    .clk(clk), .rst(rst),
    .matrix_a(matrix_a), .matrix_b(matrix_b),
    .matrix_a_stb(matrix_a_stb), .matrix_b_stb(matrix_b_stb),
    .matrix_a_ack(matrix_a_ack), .matrix_b_ack(matrix_b_ack),
    .result(result), .result_stb(result_stb), .result_ack(result_ack),
    .row(row), .column(column), .row_o_stb(row_o_stb), .column_o_stb(column_o_stb),
    .row_i_ack(row_i_ack), .column_i_ack(column_i_ack),
    .ip_out(ip_out), .ip_out_stb(ip_out_stb), .ip_out_ack(ip_out_ack)
  );

  int vectors = 0, miscompares = 0;

  task automatic chk(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic real f2r(input logic [31:0] w);
    real m;
    int  e;
    if (w[30:23] == 8'd0) return 0.0;
    m = 1.0 + real'(w[22:0]) / 8388608.0;
    e = int'(w[30:23]) - 127;
    while (e > 0) begin m = m * 2.0; e--; end
    while (e < 0) begin m = m / 2.0; e++; end
    return w[31] ? -m : m;
  endfunction

  function automatic logic [31:0] r2f(input real x);
    logic s;
    int   e;
    real  m;
    if (x == 0.0) return 32'd0;
    s = (x < 0.0);
    m = s ? -x : x;
    e = 127;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0)  begin m = m * 2.0; e--; end
    return {s, e[7:0], 23'($rtoi((m - 1.0) * 8388608.0))};
  endfunction

  function automatic logic [31:0] hsh(input vec_t x, input vec_t y);
    logic [31:0] h;
    h = 32'h9E37_79B9;
    for (int k = 0; k < N; k++) h = {h[26:0], h[31:27]} + (x[k] ^ (y[k] + 32'(k)));
    return h;
  endfunction

  // Mode 0: FP dot product, 1: sequence counter, 2: order-sensitive hash.
  function automatic logic [31:0] ipf(input int md, input int e, input vec_t x, input vec_t y);
    real         s;
    logic [31:0] v;
    case (md)
      0: begin
        s = 0.0;
        for (int k = 0; k < N; k++) s = s + f2r(x[k]) * f2r(y[k]);
        v = r2f(s);
      end
      1:       v = 32'(e);
      default: v = hsh(x, y);
    endcase
    return v;
  endfunction

  function automatic logic [MW-1:0] exp_c(input int md, input logic [MW-1:0] a, input logic [MW-1:0] b);
    logic [MW-1:0] e;
    vec_t          x, y;
    e = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        for (int k = 0; k < N; k++) begin
          x[k] = a[idx(r, k, N) +: 32];
          y[k] = b[idx(k, c, N) +: 32];
        end
        e[idx(r, c, N) +: 32] = ipf(md, r * N + c, x, y);
      end
    return e;
  endfunction

  logic [MW-1:0] ta, tb;
  logic [MW-1:0] exp_q[$];
  int  mode = 2, ack_min = 0, ack_max = 0, res_min = 1, res_max = 1, hang_elem = -1;
  bit  stale_en = 1'b0;
  int  ip_st = 0, elem = 0;

  // inner_product model; stale mode leaves ip_out_stb high into the next element's WAIT.
  initial begin : ipm
    logic [VW-1:0] xr, yc;
    vec_t cx, cy;
    int   cnt, stale_cnt, wait_cnt;
    cnt = 0; stale_cnt = 0; wait_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        ip_st = 0; elem = 0; stale_cnt = 0;
        row_i_ack = 1'b0; column_i_ack = 1'b0; ip_out_stb = 1'b0; ip_out = '0;
      end else begin
        if (stale_cnt > 0) begin
          stale_cnt--;
          if (stale_cnt == 0) ip_out_stb = 1'b0;
        end
        case (ip_st)
          0: if (row_o_stb && column_o_stb) begin
            for (int k = 0; k < N; k++) begin
              cx[k] = row[32*k +: 32];
              cy[k] = column[32*k +: 32];
              xr[32*k +: 32] = ta[idx(elem / N, k, N) +: 32];
              yc[32*k +: 32] = tb[idx(k, elem % N, N) +: 32];
            end
            chk($sformatf("row_e%0d", elem), MW'(row), MW'(xr));
            chk($sformatf("col_e%0d", elem), MW'(column), MW'(yc));
            chk("ipack_issue", MW'(ip_out_ack), MW'(1));
            cnt = int'($urandom_range(ack_max, ack_min));
            ip_st = 1;
          end
          1: if (cnt == 0) begin
            row_i_ack = 1'b1; column_i_ack = 1'b1;
            cnt = int'($urandom_range(res_max, res_min));
            ip_st = 2;
          end else cnt--;
          2: begin
            row_i_ack = 1'b0; column_i_ack = 1'b0;
            if (elem != hang_elem) begin
              if (cnt == 0) begin
                ip_out = ipf(mode, elem, cx, cy);
                ip_out_stb = 1'b1;
                wait_cnt = 0;
                ip_st = 3;
              end else cnt--;
            end
          end
          default: if (!ip_out_ack) begin
            chk("opstb_in_store", MW'(row_o_stb || column_o_stb), '0);
            if (stale_en) stale_cnt = 3;
            else ip_out_stb = 1'b0;
            elem = (elem + 1) % (N * N);
            ip_st = 0;
          end else begin
            wait_cnt++;
            if (wait_cnt > 200) begin
              chk("ipack_release_timeout", MW'(ip_out_ack), '0);
              ip_out_stb = 1'b0;
              ip_st = 0;
            end
          end
        endcase
      end
    end
  end

  // Scoreboard monitor.
  initial begin : mon
    logic          rs_prev;
    logic [MW-1:0] snap;
    rs_prev = 1'b0;
    snap = '0;
    forever begin
      @(negedge clk);
      if (!rst) rs_prev = 1'b0;
      else begin
        if (result_stb) begin
          chk("no_load_in_done", MW'({matrix_a_ack, matrix_b_ack}), '0);
          if (!rs_prev) begin
            if (exp_q.size() == 0) chk("unexpected_result", MW'(result_stb), '0);
            else chk("result", result, exp_q.pop_front());
            snap = result;
          end else chk("result_stable", result, snap);
        end
        rs_prev = result_stb;
      end
    end
  end

  task automatic idle_checks(input string tag);
    chk({tag, "_ctl"}, MW'({matrix_a_ack, matrix_b_ack, row_o_stb, column_o_stb, ip_out_ack, result_stb}), '0);
    chk({tag, "_result"}, result, '0);
    chk({tag, "_vec"}, MW'({row, column}), '0);
  endtask

  task automatic drive_load();
    exp_q.push_back(exp_c(mode, ta, tb));
    matrix_a = ta; matrix_b = tb;
    matrix_a_stb = 1'b1; matrix_b_stb = 1'b1;
  endtask

  task automatic wait_load();
    int t = 0;
    do begin @(negedge clk); t++; end while (!(matrix_a_ack && matrix_b_ack) && t < 200);
    chk("load_ack", MW'(matrix_a_ack && matrix_b_ack), MW'(1));
    matrix_a_stb = 1'b0; matrix_b_stb = 1'b0;
  endtask

  task automatic wait_result();
    int t = 0;
    while (!result_stb && t < 3000) begin @(negedge clk); t++; end
    chk("result_stb_seen", MW'(result_stb), MW'(1));
  endtask

  task automatic finish_run();
    wait_result();
    repeat ($urandom_range(3, 0)) @(negedge clk);
    result_ack = 1'b1;
    @(negedge clk);
    result_ack = 1'b0;
  endtask

  task automatic rand_mats();
    for (int i = 0; i < N * N; i++) begin
      ta[32*i +: 32] = $urandom;
      tb[32*i +: 32] = $urandom;
    end
  endtask

  task automatic ident_mats();
    ta = '0;
    for (int i = 0; i < N * N; i++) tb[32*i +: 32] = 32'h4000_0000;
    for (int r = 0; r < N; r++) ta[idx(r, r, N) +: 32] = 32'h3F80_0000;
  endtask

  initial begin : wdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int t;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (20) begin @(negedge clk); idle_checks("idle"); end

    mode = 0; ack_min = 0; ack_max = 0; res_min = 10; res_max = 10;
    ident_mats();
    drive_load(); wait_load(); finish_run();

    mode = 1; ack_min = 0; ack_max = 2; res_min = 1; res_max = 3;
    rand_mats();
    drive_load(); wait_load(); finish_run();

    mode = 2; ack_min = 5; ack_max = 5; res_min = 20; res_max = 20; stale_en = 1'b1;
    rand_mats();
    drive_load(); wait_load(); finish_run();
    stale_en = 1'b0;

    // Result held while new operands are already offered.
    ack_min = 0; ack_max = 2; res_min = 1; res_max = 4;
    rand_mats();
    drive_load(); wait_load(); wait_result();
    rand_mats();
    drive_load();
    repeat (10) @(negedge clk);
    result_ack = 1'b1;
    @(negedge clk);
    result_ack = 1'b0;
    wait_load(); finish_run();

    // Reset while waiting on element (2,1).
    mode = 0; ack_min = 0; ack_max = 1; res_min = 2; res_max = 4; hang_elem = 9;
    ident_mats();
    drive_load(); wait_load();
    t = 0;
    while (!(elem == 9 && ip_st == 2) && t < 1000) begin @(negedge clk); t++; end
    chk("reached_wait_2_1", MW'(elem == 9 && ip_st == 2), MW'(1));
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1 idle_checks("async_rst");
    chk("pending_exp", MW'(exp_q.size()), MW'(1));
    exp_q.delete();
    hang_elem = -1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    drive_load(); wait_load(); finish_run();

    mode = 2;
    for (int i = 0; i < 3; i++) begin
      ack_min = 0; ack_max = 3; res_min = 2; res_max = 6;
      stale_en = 1'($urandom_range(1, 0));
      rand_mats();
      drive_load(); wait_load(); finish_run();
    end
    repeat (8) @(negedge clk);
    chk("scoreboard_drained", MW'(exp_q.size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
